// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN image path: image geometry and the
// state encoding of the RAM-to-UART dump sequencer.
package cnn_pkg;

  // One 28x28 binary image, one bit per RAM word.
  localparam int IMG_BITS  = 784;
  // Bits packed into each UART byte.
  localparam int BYTE_BITS = 8;

  // Dump sequencer states:
  //   IDLE    waiting for strt
  //   FILL    walking the 8 addresses of one byte, capturing the previous read
  //   LAST    capturing the read of the byte's final address
  //   XMIT    handing the packed byte to the UART (trmt high)
  //   WAIT_TX waiting for the UART to finish shifting the byte out
  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LAST,
    XMIT,
    WAIT_TX
  } dump_state_t;

endpackage

// File: rtl/cnn_bit_packer.sv
// Eight-bit assembly register for the dump path. Each captured RAM bit is
// written to the position given by idx, so bit k of the byte comes from
// the k-th address of the group (LSB first). The register also serves as
// the UART data word, so it holds its value between captures.
module cnn_bit_packer
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 cap,
  input  logic [2:0]           idx,
  input  logic                 din,
  output logic [BYTE_BITS-1:0] byte_q
);

  // Clear on request, otherwise write the captured bit into its slot.
  // NOTE: this register is reset even though every bit is rewritten before
  // use, because it drives tx_data directly and that output must read 0
  // out of reset rather than an unknown value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
    end else if (clr) begin
      byte_q <= '0;
    end else if (cap) begin
      // NOTE: non-blocking assignment so every register in the design sees
      // pre-edge values regardless of evaluation order between blocks.
      byte_q[idx] <= din;
    end
  end

endmodule

// File: rtl/cnn_ram_dump_tx.sv
// Dumps the 1-bit-wide input image RAM to the host over the UART.
// Eight consecutive RAM bits form one byte, LSB first: the bit at address
// 8*n+k becomes bit k of byte n. Each byte is fetched (8 reads with one
// cycle of RAM latency), handed to the UART with a one-cycle trmt, and the
// next byte is fetched only after tx_done, so a byte costs 10 cycles plus
// the UART frame time.
module cnn_ram_dump_tx
  import cnn_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NUM_BYTES = IMG_BITS / BYTE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt,
  output logic [ADDR_W-1:0] addr_rd,
  input  logic              din,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              bsy,
  output logic              done
);

  localparam int CNT_W = $clog2(NUM_BYTES);

  dump_state_t      state;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0]       bit_cnt;

  logic             start_ok;
  logic             last_byte;
  logic             pk_clr;
  logic             pk_cap;
  logic [2:0]       pk_idx;
  logic [7:0]       pk_byte;

  // First RAM address of byte n.
  function automatic logic [ADDR_W-1:0] byte_base(input logic [CNT_W-1:0] n);
    return ADDR_W'({n, 3'b000});
  endfunction

  // A strt coinciding with the done pulse belongs to the dump that is just
  // finishing, so it is not allowed to launch a new one.
  assign start_ok  = (state == IDLE) && strt && !done;
  assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));

  // Packer control: each FILL cycle after the first captures the read
  // issued one cycle earlier; LAST captures the read of address base+7.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    pk_clr = start_ok;
    pk_cap = 1'b0;
    pk_idx = 3'd0;
    case (state)
      FILL: begin
        if (bit_cnt != 3'd0) begin
          pk_cap = 1'b1;
          pk_idx = bit_cnt - 3'd1;
        end
      end
      LAST: begin
        pk_cap = 1'b1;
        pk_idx = 3'd7;
      end
      default: ;
    endcase
  end

  cnn_bit_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr    (pk_clr),
    .cap    (pk_cap),
    .idx    (pk_idx),
    .din    (din),
    .byte_q (pk_byte)
  );

  // The packer register only changes during FILL/LAST, so it is stable from
  // trmt through tx_done and keeps the last byte while idle.
  assign tx_data = pk_byte;

  // Dump sequencer: state, counters, read address and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      addr_rd  <= '0;
      trmt     <= 1'b0;
      bsy      <= 1'b0;
      done     <= 1'b0;
    end else begin
      trmt <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          addr_rd <= '0;
          if (start_ok) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
            bsy      <= 1'b1;
            state    <= FILL;
          end
        end

        FILL: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            // Address stays on base+7 while LAST consumes its data.
            state <= LAST;
          end else begin
            addr_rd <= addr_rd + ADDR_W'(1);
          end
        end

        LAST: begin
          // trmt is registered here so it is high during the XMIT cycle,
          // the same cycle the completed byte appears on tx_data.
          trmt  <= 1'b1;
          state <= XMIT;
        end

        XMIT: begin
          state <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_done) begin
            if (last_byte) begin
              done    <= 1'b1;
              bsy     <= 1'b0;
              addr_rd <= '0;
              state   <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
              bit_cnt  <= '0;
              addr_rd  <= byte_base(byte_cnt + CNT_W'(1));
              state    <= FILL;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_ram_dump_tx.sv
// Directed bench for cnn_ram_dump_tx: a behavioural 1-bit RAM with one
// cycle of read latency, a hand-driven UART handshake, and expected bytes
// built from the RAM contents with the 8*n+k -> byte n bit k mapping.
module tb_cnn_ram_dump_tx;

  localparam int ADDR_W    = 10;
  localparam int NUM_BYTES = 98;
  localparam int LAT       = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              strt;
  logic [ADDR_W-1:0] addr_rd;
  logic              din;
  logic              trmt;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              bsy;
  logic              done;

  logic ram [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_errors = 0;
  int trmt_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  cnn_ram_dump_tx #(
    .ADDR_W    (ADDR_W),
    .NUM_BYTES (NUM_BYTES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .strt    (strt),
    .addr_rd (addr_rd),
    .din     (din),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .bsy     (bsy),
    .done    (done)
  );

  // Synchronous-read RAM: data for an address appears the next cycle.
  always @(posedge clk) din <= ram[addr_rd];

  // Count cycles with trmt / done high; a stretched pulse inflates the count.
  always @(negedge clk) begin
    if (trmt) trmt_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = ram[b*8 + k];
    return r;
  endfunction

  // Pulse strt (use_txd=0) or tx_done (use_txd=1) for one cycle and count
  // cycles until trmt. Checks the first and last read address of the byte.
  // With inj set, a spurious strt and tx_done are driven during FILL.
  task automatic pulse_wait(input string tag, input bit use_txd, input bit also_txd,
                            input logic [ADDR_W-1:0] base, input bit inj, output int lat);
    int k;
    k = 0;
    if (use_txd) tx_done = 1'b1;
    else         strt    = 1'b1;
    if (also_txd) tx_done = 1'b1;
    while (k < 200) begin
      @(negedge clk);
      k++;
      strt    = inj && (k == 3);
      tx_done = inj && (k == 3);
      if (k == 1) check({tag, "_addr_first"}, addr_rd, base);
      if (k == 8) check({tag, "_addr_last"}, addr_rd, base + ADDR_W'(7));
      if (trmt) break;
    end
    if (!trmt) check({tag, "_trmt_seen"}, trmt, 1);
    lat = k;
  endtask

  // One dump: checks every byte, the per-byte latency, done and bsy at the
  // end. inj_byte gets spurious strt/tx_done; rst_byte aborts with reset
  // during that byte's WAIT_TX.
  task automatic run_dump(input string tag, input int gap, input int inj_byte,
                          input int rst_byte, input bit strt_with_txd,
                          output logic [7:0] last_tx);
    int lat, t0, d0;
    t0 = trmt_cnt;
    d0 = done_cnt;
    last_tx = '0;
    pulse_wait({tag, "_b0"}, 1'b0, strt_with_txd, '0, inj_byte == 0, lat);
    check({tag, "_lat_strt"}, lat, LAT);
    for (int b = 0; b < NUM_BYTES; b++) begin
      check($sformatf("%s_byte%0d", tag, b), tx_data, exp_byte(b));
      last_tx = tx_data;
      if (b == rst_byte) begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_rst_trmt"}, trmt, 0);
        check({tag, "_rst_bsy"}, bsy, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_addr"}, addr_rd, 0);
        check({tag, "_rst_txdata"}, tx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_trmt_cnt"}, trmt_cnt - t0, b + 1);
        check({tag, "_done_cnt"}, done_cnt - d0, 0);
        return;
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        strt = (b == inj_byte) && (g == 2);
      end
      strt = 1'b0;
      if (b < NUM_BYTES - 1) begin
        pulse_wait($sformatf("%s_b%0d", tag, b + 1), 1'b1, 1'b0,
                   ADDR_W'((b + 1) * 8), (b + 1) == inj_byte, lat);
        check($sformatf("%s_lat%0d", tag, b + 1), lat, LAT);
      end else begin
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({tag, "_done_pulse"}, done, 1);
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
        check({tag, "_done_single"}, done, 0);
        check({tag, "_bsy_after"}, bsy, 0);
        repeat (2) @(negedge clk);
        check({tag, "_bsy_idle"}, bsy, 0);
        check({tag, "_trmt_cnt"}, trmt_cnt - t0, NUM_BYTES);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
      end
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] last;
    logic [7:0] pat;
    logic [7:0] v;

    rst     = 1'b1;
    strt    = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_trmt", trmt, 0);
    check("reset_bsy", bsy, 0);
    check("reset_done", done, 0);
    check("reset_addr", addr_rd, 0);
    check("reset_txdata", tx_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: bits 0..7 = 1,0,1,0,0,1,0,1 -> 8'hA5 after 10 cycles.
    pat = 8'hA5;
    for (int k = 0; k < 8; k++) ram[k] = pat[k];
    pulse_wait("t1", 1'b0, 1'b0, '0, 1'b0, lat);
    check("t1_lat", lat, LAT);
    check("t1_data", tx_data, 8'hA5);
    check("t1_bsy", bsy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 2: alternating bits (even addresses 1) -> every byte 8'h55.
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = (i % 2 == 0);
    run_dump("t2", 20, -1, -1, 1'b0, last);
    check("t2_last_byte", last, 8'h55);

    // Tests 3 and 4: distinct bytes; extra strt in FILL and WAIT_TX of
    // byte 5, spurious tx_done in its FILL.
    for (int n = 0; n < NUM_BYTES; n++) begin
      v = 8'(n * 37 + 11);
      for (int k = 0; k < 8; k++) ram[n*8 + k] = v[k];
    end
    run_dump("t34", 4, 5, -1, 1'b0, last);

    // Test 5: reset during WAIT_TX of byte 40.
    run_dump("t5", 4, -1, 40, 1'b0, last);

    // Test 6: last byte all ones, started with strt and tx_done together.
    for (int i = 776; i < 784; i++) ram[i] = 1'b1;
    run_dump("t6", 3, -1, -1, 1'b1, last);
    check("t6_last_byte", last, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
